// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared FSM state types, fixed AXI attribute values and grant-width helper
package axi_arb_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [3:0] CACHE_NONE  = 4'b0000;
  localparam logic [2:0] PROT_NONE   = 3'b000;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_picker.sv
// arb_picker: picks one requester, round-robin after last grant or fixed lowest-index priority
module arb_picker import axi_arb_pkg::*; #(
  parameter int N  = 2,
  parameter int GW = grant_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_i,
  input  logic          rr_i,
  output logic [GW-1:0] grant_o
);

  logic found;
  int   idx;

  // scan candidates in priority order and keep the first one that is requesting
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = rr_i ? (int'(last_i) + 1 + i) % N : i;
      if (!found && |(req_i & (N'(1) << idx))) begin
        grant_o = GW'(idx);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: muxes NUM_M cache masters onto one AXI3 master port, independent read and write FSMs
module axi_rr_arbiter import axi_arb_pkg::*; #(
  parameter int NUM_M   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int RR_MODE = 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_M*ADDR_W-1:0]    m_araddr,
  input  logic [NUM_M*8-1:0]         m_arlen,
  input  logic [NUM_M*3-1:0]         m_arsize,
  input  logic [NUM_M-1:0]           m_arvalid,
  output logic [NUM_M-1:0]           m_arready,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_rlast,
  output logic [NUM_M-1:0]           m_rvalid,
  input  logic [NUM_M-1:0]           m_rready,
  input  logic [NUM_M*ADDR_W-1:0]    m_awaddr,
  input  logic [NUM_M*8-1:0]         m_awlen,
  input  logic [NUM_M*3-1:0]         m_awsize,
  input  logic [NUM_M-1:0]           m_awvalid,
  output logic [NUM_M-1:0]           m_awready,
  input  logic [NUM_M*DATA_W-1:0]    m_wdata,
  input  logic [NUM_M*DATA_W/8-1:0]  m_wstrb,
  input  logic [NUM_M-1:0]           m_wlast,
  input  logic [NUM_M-1:0]           m_wvalid,
  output logic [NUM_M-1:0]           m_wready,
  output logic [NUM_M-1:0]           m_bvalid,
  input  logic [NUM_M-1:0]           m_bready,
  output logic [ID_W-1:0]            arid,
  output logic [ADDR_W-1:0]          araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic [1:0]                 arlock,
  output logic [3:0]                 arcache,
  output logic [2:0]                 arprot,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [ID_W-1:0]            rid,
  input  logic [DATA_W-1:0]          rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic [ID_W-1:0]            awid,
  output logic [ADDR_W-1:0]          awaddr,
  output logic [7:0]                 awlen,
  output logic [2:0]                 awsize,
  output logic [1:0]                 awburst,
  output logic [1:0]                 awlock,
  output logic [3:0]                 awcache,
  output logic [2:0]                 awprot,
  output logic                       awvalid,
  input  logic                       awready,
  output logic [ID_W-1:0]            wid,
  output logic [DATA_W-1:0]          wdata,
  output logic [DATA_W/8-1:0]        wstrb,
  output logic                       wlast,
  output logic                       wvalid,
  input  logic                       wready,
  input  logic [ID_W-1:0]            bid,
  input  logic [1:0]                 bresp,
  input  logic                       bvalid,
  output logic                       bready
);

  localparam int GW = grant_w(NUM_M);
  localparam int SW = DATA_W / 8;

  r_state_e         r_state_q;
  w_state_e         w_state_q;
  logic [GW-1:0]    r_grant_q, r_last_q, r_pick;
  logic [GW-1:0]    w_grant_q, w_last_q, w_pick;
  logic [NUM_M-1:0] r_sel, w_sel;
  logic             r_addr, r_data, w_addr, w_data, w_resp;
  logic             unused_resp;

  // response IDs and codes never steer routing; the FSM grant alone decides
  assign unused_resp = ^{rid, rresp, bid, bresp};

  arb_picker #(.N(NUM_M), .GW(GW)) u_r_pick (
    .req_i   (m_arvalid),
    .last_i  (r_last_q),
    .rr_i    (RR_MODE != 0),
    .grant_o (r_pick)
  );

  arb_picker #(.N(NUM_M), .GW(GW)) u_w_pick (
    .req_i   (m_awvalid),
    .last_i  (w_last_q),
    .rr_i    (RR_MODE != 0),
    .grant_o (w_pick)
  );

  assign r_sel  = NUM_M'(1) << r_grant_q;
  assign w_sel  = NUM_M'(1) << w_grant_q;
  assign r_addr = r_state_q == R_ADDR;
  assign r_data = r_state_q == R_DATA;
  assign w_addr = w_state_q == W_ADDR;
  assign w_data = w_state_q == W_DATA;
  assign w_resp = w_state_q == W_RESP;

  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign arlock  = LOCK_NORMAL;
  assign awlock  = LOCK_NORMAL;
  assign arcache = CACHE_NONE;
  assign awcache = CACHE_NONE;
  assign arprot  = PROT_NONE;
  assign awprot  = PROT_NONE;

  assign arvalid   = r_addr;
  assign arid      = ID_W'(r_grant_q);
  assign araddr    = ADDR_W'(m_araddr >> (int'(r_grant_q) * ADDR_W));
  assign arlen     = 8'(m_arlen >> (int'(r_grant_q) * 8));
  assign arsize    = 3'(m_arsize >> (int'(r_grant_q) * 3));
  assign m_arready = (r_addr && arready) ? r_sel : '0;
  assign rready    = r_data && |(m_rready & r_sel);
  assign m_rvalid  = (r_data && rvalid) ? r_sel : '0;
  assign m_rdata   = rdata;
  assign m_rlast   = rlast;

  assign awvalid   = w_addr;
  assign awid      = ID_W'(w_grant_q);
  assign wid       = ID_W'(w_grant_q);
  assign awaddr    = ADDR_W'(m_awaddr >> (int'(w_grant_q) * ADDR_W));
  assign awlen     = 8'(m_awlen >> (int'(w_grant_q) * 8));
  assign awsize    = 3'(m_awsize >> (int'(w_grant_q) * 3));
  assign m_awready = (w_addr && awready) ? w_sel : '0;
  assign wvalid    = w_data && |(m_wvalid & w_sel);
  assign wlast     = w_data && |(m_wlast & w_sel);
  assign wdata     = w_data ? DATA_W'(m_wdata >> (int'(w_grant_q) * DATA_W)) : '0;
  assign wstrb     = w_data ? SW'(m_wstrb >> (int'(w_grant_q) * SW)) : '0;
  assign m_wready  = (w_data && wready) ? w_sel : '0;
  assign bready    = w_resp && |(m_bready & w_sel);
  assign m_bvalid  = (w_resp && bvalid) ? w_sel : '0;

  // read channel: grant on any request, hold it until the rlast handshake
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_grant_q <= '0;
      r_last_q  <= GW'(NUM_M - 1);
    end else begin
      case (r_state_q)
        R_IDLE: if (|m_arvalid) begin
          r_state_q <= R_ADDR;
          r_grant_q <= r_pick;
        end
        R_ADDR: if (arready) r_state_q <= R_DATA;
        R_DATA: if (rvalid && rready && rlast) begin
          r_state_q <= R_IDLE;
          r_last_q  <= r_grant_q;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end

  // write channel: grant, address, data up to wlast, then wait for the response
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_grant_q <= '0;
      w_last_q  <= GW'(NUM_M - 1);
    end else begin
      case (w_state_q)
        W_IDLE: if (|m_awvalid) begin
          w_state_q <= W_ADDR;
          w_grant_q <= w_pick;
        end
        W_ADDR: if (awready) w_state_q <= W_DATA;
        W_DATA: if (wvalid && wready && wlast) w_state_q <= W_RESP;
        W_RESP: if (bvalid && bready) begin
          w_state_q <= W_IDLE;
          w_last_q  <= w_grant_q;
        end
      endcase
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb_axi_rr_arbiter: directed scoreboard bench, round-robin instance plus a fixed-priority twin
module tb_axi_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic aclk, aresetn;
  logic [N*AW-1:0]   m_araddr, m_awaddr;
  logic [N*8-1:0]    m_arlen, m_awlen;
  logic [N*3-1:0]    m_arsize, m_awsize;
  logic [N-1:0]      m_arvalid, m_rready, m_awvalid, m_wlast, m_wvalid, m_bready;
  logic [N*DW-1:0]   m_wdata;
  logic [N*DW/8-1:0] m_wstrb;
  logic              arready, rlast, rvalid, awready, wready, bvalid;
  logic [IW-1:0]     rid, bid;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp, bresp;

  logic [N-1:0]  m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [DW-1:0] m_rdata, wdata;
  logic          m_rlast, arvalid, rready, awvalid, wlast, wvalid, bready;
  logic [IW-1:0] arid, awid, wid;
  logic [AW-1:0] araddr, awaddr;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize, arprot, awprot;
  logic [1:0]    arburst, awburst, arlock, awlock;
  logic [3:0]    arcache, awcache;
  logic [DW/8-1:0] wstrb;

  logic [N-1:0]  fp_m_arready, fp_m_rvalid, fp_m_awready, fp_m_wready, fp_m_bvalid;
  logic [DW-1:0] fp_m_rdata, fp_wdata;
  logic          fp_m_rlast, fp_arvalid, fp_rready, fp_awvalid, fp_wlast, fp_wvalid, fp_bready;
  logic [IW-1:0] fp_arid, fp_awid, fp_wid;
  logic [AW-1:0] fp_araddr, fp_awaddr;
  logic [7:0]    fp_arlen, fp_awlen;
  logic [2:0]    fp_arsize, fp_awsize, fp_arprot, fp_awprot;
  logic [1:0]    fp_arburst, fp_awburst, fp_arlock, fp_awlock;
  logic [3:0]    fp_arcache, fp_awcache;
  logic [DW/8-1:0] fp_wstrb;

  int total, bad;
  int rq[$];
  int wq[$];
  int rd_beats[N];
  bit chk_fp;

  axi_rr_arbiter #(.NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .RR_MODE(1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_rr_arbiter #(.NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .RR_MODE(0)) dut_fp (
    .aclk(aclk), .aresetn(aresetn),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(fp_m_arready),
    .m_rdata(fp_m_rdata), .m_rlast(fp_m_rlast), .m_rvalid(fp_m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(fp_m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(fp_m_wready),
    .m_bvalid(fp_m_bvalid), .m_bready(m_bready),
    .arid(fp_arid), .araddr(fp_araddr), .arlen(fp_arlen), .arsize(fp_arsize), .arburst(fp_arburst), .arlock(fp_arlock),
    .arcache(fp_arcache), .arprot(fp_arprot), .arvalid(fp_arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(fp_rready),
    .awid(fp_awid), .awaddr(fp_awaddr), .awlen(fp_awlen), .awsize(fp_awsize), .awburst(fp_awburst), .awlock(fp_awlock),
    .awcache(fp_awcache), .awprot(fp_awprot), .awvalid(fp_awvalid), .awready(awready),
    .wid(fp_wid), .wdata(fp_wdata), .wstrb(fp_wstrb), .wlast(fp_wlast), .wvalid(fp_wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(fp_bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] raddr_of(input int id);
    return 32'h1000 * (id + 1);
  endfunction

  function automatic logic [31:0] waddr_of(input int id);
    return 32'h8000 + 32'h100 * id;
  endfunction

  function automatic logic [31:0] wdat_of(input int id);
    return 32'hA5A5_0000 + id;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic req_rd(input int id, input int beats);
    rd_beats[id] = beats;
    m_araddr[id*AW +: AW] = raddr_of(id);
    m_arlen[id*8 +: 8] = 8'(beats - 1);
    m_arsize[id*3 +: 3] = 3'd2;
    m_arvalid[id] = 1'b1;
  endtask

  task automatic req_wr(input int id);
    m_awaddr[id*AW +: AW] = waddr_of(id);
    m_awlen[id*8 +: 8] = 8'd0;
    m_awsize[id*3 +: 3] = 3'd2;
    m_awvalid[id] = 1'b1;
  endtask

  task automatic rst_pulse();
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic rd_txn(input int stall_at, input int stall_len, input bit keep);
    int g, n, w;
    logic [N-1:0] sel;
    w = 0;
    n = 0;
    while (!arvalid && w < 20) begin
      @(negedge aclk);
      w++;
    end
    chk("ar_latency", w, 1);
    if (!arvalid) return;
    g = rq.pop_front();
    sel = N'(1) << g;
    chk("arid", arid, g);
    chk("araddr", araddr, raddr_of(g));
    chk("arlen", arlen, rd_beats[g] - 1);
    if (chk_fp) begin
      chk("fp_arvalid", fp_arvalid, 1);
      chk("fp_arid", fp_arid, 0);
    end
    chk("m_arready_wait", m_arready, 0);
    arready = 1'b1;
    #1 chk("m_arready", m_arready, sel);
    @(negedge aclk);
    arready = 1'b0;
    if (!keep) m_arvalid[g] = 1'b0;
    chk("arvalid_off", arvalid, 0);
    for (int b = 0; b < rd_beats[g]; b++) begin
      rvalid = 1'b1;
      rdata = 32'hD000_0000 | (g << 8) | b;
      rlast = (b == rd_beats[g] - 1);
      if (b == stall_at) begin
        m_rready[g] = 1'b0;
        repeat (stall_len) begin
          #1 chk("rready_stall", rready, 0);
          chk("m_rvalid_stall", m_rvalid, sel);
          @(negedge aclk);
        end
        m_rready[g] = 1'b1;
      end
      #1 chk("m_rvalid", m_rvalid, sel);
      chk("rready", rready, 1);
      chk("m_rdata", m_rdata, rdata);
      chk("m_rlast", m_rlast, rlast);
      if (m_rvalid[g] && rready) n++;
      @(negedge aclk);
    end
    chk("beat_count", n, rd_beats[g]);
    #1 chk("r_exit", m_rvalid, 0);
    chk("r_idle_gap", arvalid, 0);
    rvalid = 1'b0;
    rlast = 1'b0;
  endtask

  task automatic wr_txn();
    int g, w;
    logic [N-1:0] sel;
    w = 0;
    while (!awvalid && w < 20) begin
      @(negedge aclk);
      w++;
    end
    chk("aw_latency", w, 1);
    if (!awvalid) return;
    g = wq.pop_front();
    sel = N'(1) << g;
    chk("awid", awid, g);
    chk("awaddr", awaddr, waddr_of(g));
    awready = 1'b1;
    #1 chk("m_awready", m_awready, sel);
    @(negedge aclk);
    awready = 1'b0;
    m_awvalid[g] = 1'b0;
    chk("awvalid_off", awvalid, 0);
    m_wdata[g*DW +: DW] = wdat_of(g);
    m_wstrb[g*DW/8 +: DW/8] = '1;
    m_wlast[g] = 1'b1;
    m_wvalid[g] = 1'b1;
    wready = 1'b1;
    #1 chk("wvalid", wvalid, 1);
    chk("wdata", wdata, wdat_of(g));
    chk("wid", wid, g);
    chk("wlast", wlast, 1);
    chk("m_wready", m_wready, sel);
    @(negedge aclk);
    m_wvalid[g] = 1'b0;
    m_wlast[g] = 1'b0;
    wready = 1'b0;
    bvalid = 1'b1;
    #1 chk("m_bvalid", m_bvalid, sel);
    chk("bready", bready, 1);
    chk("wvalid_resp", wvalid, 0);
    @(negedge aclk);
    #1 chk("b_exit", m_bvalid, 0);
    bvalid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    chk_fp = 1'b0;
    aresetn = 1'b0;
    m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arvalid = '0; m_rready = '1;
    m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awvalid = '0;
    m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '1;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    repeat (2) @(negedge aclk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_master_out", {m_arready, m_rvalid, m_awready, m_wready, m_bvalid}, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("arburst", arburst, 2'b01);
    chk("awburst", awburst, 2'b01);
    chk("attr_zero", {arlock, awlock, arcache, awcache, arprot, awprot}, 0);

    // two masters request together: master 0 first, then master 1
    req_rd(0, 1);
    req_rd(1, 1);
    rq.push_back(0);
    rq.push_back(1);
    rd_txn(-1, 0, 1'b0);
    rd_txn(-1, 0, 1'b0);

    // 4-beat read for master 1 concurrent with a 1-beat write for master 0
    req_rd(1, 4);
    req_wr(0);
    rq.push_back(1);
    wq.push_back(0);
    fork
      rd_txn(-1, 0, 1'b0);
      wr_txn();
    join

    // 4-beat read with rready held off for 3 cycles on beat 2
    req_rd(2, 4);
    rq.push_back(2);
    rd_txn(1, 3, 1'b0);

    // reset in the middle of a write data phase for master 1
    req_wr(1);
    @(negedge aclk);
    chk("rst_aw_up", awvalid, 1);
    chk("rst_awid", awid, 1);
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0;
    m_awvalid[1] = 1'b0;
    m_wdata[DW +: DW] = wdat_of(1);
    m_wlast[1] = 1'b1;
    m_wvalid[1] = 1'b1;
    wready = 1'b1;
    #1 chk("rst_wvalid_pre", wvalid, 1);
    chk("rst_m_wready_pre", m_wready, 3'b010);
    #1 aresetn = 1'b0;
    #1 chk("rst_async_wvalid", wvalid, 0);
    chk("rst_async_m_wready", m_wready, 0);
    chk("rst_async_awvalid", awvalid, 0);
    @(negedge aclk);
    bvalid = 1'b1;
    #1 chk("rst_no_bvalid", m_bvalid, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    m_wvalid = '0;
    m_wlast = '0;
    wready = 1'b0;
    #1 chk("rst_no_bvalid_idle", m_bvalid, 0);
    @(negedge aclk);
    bvalid = 1'b0;
    req_wr(0);
    req_wr(1);
    wq.push_back(0);
    wq.push_back(1);
    wr_txn();
    wr_txn();

    // all three masters request continuously from reset
    rst_pulse();
    chk_fp = 1'b1;
    req_rd(0, 1);
    req_rd(1, 1);
    req_rd(2, 1);
    rq.push_back(0);
    rq.push_back(1);
    rq.push_back(2);
    rq.push_back(0);
    repeat (4) rd_txn(-1, 0, 1'b1);
    chk_fp = 1'b0;
    m_arvalid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_rr_arbiter.md
AXI_RR_ARBITER -- requirements
Module: axi_rr_arbiter

Interface
REQ-001 SHALL have one clock and one reset: asynchronous, active-low.
REQ-002 SHALL take these parameters (name, default, meaning):
- NUM_M, 2: number of cache masters, 1..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- ID_W, 4: AXI ID width, >= clog2(NUM_M).
- RR_MODE, 1: 1 = round-robin, 0 = fixed priority (index 0 highest).

REQ-003 SHALL have these ports (name, direction, width, meaning). Per-master vectors are flattened, master i at slice i.
- aclk, input, 1: clock.
- aresetn, input, 1: asynchronous active-low reset.
- m_araddr/m_arlen/m_arsize, input, NUM_M*{ADDR_W,8,3}: master read address fields.
- m_arvalid, input, NUM_M: master read request.
- m_arready, output, NUM_M: master read request accepted.
- m_rdata/m_rlast, output, DATA_W/1: read data and last beat, broadcast to all masters.
- m_rvalid, output, NUM_M: read data valid, per master.
- m_rready, input, NUM_M: master ready for read data.
- m_awaddr/m_awlen/m_awsize, input, NUM_M*{ADDR_W,8,3}: master write address fields.
- m_awvalid, input, NUM_M: master write request.
- m_awready, output, NUM_M: master write request accepted.
- m_wdata/m_wstrb/m_wlast, input, NUM_M*{DATA_W,DATA_W/8,1}: master write data fields.
- m_wvalid, input, NUM_M: master write data valid.
- m_wready, output, NUM_M: master write data accepted.
- m_bvalid, output, NUM_M: write response valid, per master.
- m_bready, input, NUM_M: master ready for write response.
- ar*/r*/aw*/w*/b*: standard AXI3 outer master ports at full widths; arlock/awlock 2 bits; wid present.

Function
REQ-004 SHALL run the read channel and the write channel as independent FSMs, concurrently; each FSM has one outstanding transaction.
REQ-005 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA.
- R_IDLE -> R_ADDR when any m_arvalid is high; the grant index is registered.
- R_ADDR -> R_DATA on arvalid && arready.
- R_DATA -> R_IDLE on rvalid && rready && rlast.
REQ-006 Write FSM SHALL have states W_IDLE, W_ADDR, W_DATA, W_RESP.
- W_IDLE -> W_ADDR when any m_awvalid is high.
- W_ADDR -> W_DATA on the aw handshake.
- W_DATA -> W_RESP on the w handshake with wlast.
- W_RESP -> W_IDLE on bvalid && bready.
REQ-007 In R_ADDR, arvalid SHALL be 1 and araddr/arlen/arsize SHALL be the granted master's fields; arid SHALL equal the grant index.
REQ-008 m_arready[g] SHALL equal arready while in R_ADDR; all other m_arready bits SHALL be 0.
REQ-009 Latency SHALL be exactly 1 cycle from m_arvalid (or m_awvalid) rising in IDLE to outer arvalid (or awvalid).
REQ-010 In R_DATA, m_rvalid[g] SHALL equal rvalid and rready SHALL equal m_rready[g]; m_rvalid SHALL be 0 for all other masters and in every other state.
REQ-011 The write path SHALL mirror REQ-007..010:
- awid = wid = grant index.
- w* routed from the granted master in W_DATA only.
- m_bvalid[g] = bvalid in W_RESP only.
REQ-012 Outer ports SHALL be constant: arburst = awburst = 2'b01 (INCR); lock, cache and prot = 0.
REQ-013 Grant selection:
- RR_MODE = 1: pick the first requester scanning from last_grant+1 with wrap-around modulo NUM_M.
- RR_MODE = 0: pick the lowest requesting index.
REQ-014 last_grant SHALL update only on transaction completion; the read and write channels each keep their own last_grant.
REQ-015 With NUM_M = 1, the grant SHALL always be 0.
REQ-016 rid, bid, rresp and bresp SHALL NOT affect routing; routing SHALL be by FSM grant only.
REQ-017 A new request and a completion in the same cycle SHALL give IDLE for one cycle before the next grant; there is no back-to-back grant.

Reset
REQ-018 Reset SHALL act immediately:
- both FSMs go to IDLE;
- each last_grant = NUM_M-1, so master 0 wins first;
- all valid/ready outputs = 0.
REQ-019 Reset mid-burst SHALL abandon the transaction; no completion is signalled to any master.

Structure
REQ-020 Package axi_arb_pkg SHALL hold the FSM state enums, the INCR/lock/cache/prot constants, and a grant-index width function.
REQ-021 Sub-module arb_picker (req vector, last_grant, mode -> grant index) SHALL be instantiated once per channel.

Verification
REQ-022 NUM_M = 2, masters 0 and 1 assert arvalid in the same cycle -> master 0 is granted first (arid = 0); after its rlast, master 1 is granted (arid = 1).
REQ-023 RR_MODE = 1, NUM_M = 3, all three masters request continuously -> grants run 0, 1, 2, 0; RR_MODE = 0 -> grants are always 0.
REQ-024 A 4-beat read (arlen = 3) for master 1 runs concurrently with a 1-beat write for master 0 -> both complete; m_rvalid[0] = 0 and m_bvalid[1] = 0 throughout.
REQ-025 rready is stalled 3 cycles during beat 2 of 4 -> no beat is lost or duplicated; R_DATA -> R_IDLE exactly at the rlast handshake.
REQ-026 aresetn is pulsed low during W_DATA -> outputs zero asynchronously; the next write grant goes to master 0.
